// File: rtl/bin2bcd_if.sv
// Handshake bundle for bin2bcd_seq: binary word in, packed BCD (and optional Excess-3) out.
// BIN2BCD_EXCESS3_EN adds the ex3_out signal.
interface bin2bcd_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  out_ovf;
  logic                  busy;
`ifdef BIN2BCD_EXCESS3_EN
  logic [4*DIGITS-1:0]   ex3_out;
`endif

  modport master (
    output in_valid, bin_in, out_ready,
`ifdef BIN2BCD_EXCESS3_EN
    input  ex3_out,
`endif
    input  in_ready, out_valid, bcd_out, out_ovf, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
`ifdef BIN2BCD_EXCESS3_EN
    output ex3_out,
`endif
    output in_ready, out_valid, bcd_out, out_ovf, busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Optional feature macro: BIN2BCD_EXCESS3_EN (registered Excess-3 copy of the result).
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  bin2bcd_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic logic [BCD_W-1:0] dab_correct(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic [BIN_W-1:0]  bin_sr;
  logic [BCD_W-1:0]  acc;
  logic              ovf;
  logic [BCD_W-1:0]  bcd_q;
  logic              ovf_q;
  logic              vld_q;

  logic [BCD_W-1:0]  acc_fix;
  logic [BCD_W-1:0]  acc_next;
  logic              carry;

  assign acc_fix  = dab_correct(acc);
  assign acc_next = {acc_fix[BCD_W-2:0], bin_sr[BIN_W-1]};
  // A set bit 3 on the corrected top digit leaves the window: value >= 10^DIGITS.
  assign carry    = acc_fix[BCD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      bin_sr <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin_sr <= bus.bin_in;
            acc    <= '0;
            ovf    <= 1'b0;
            count  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc    <= acc_next;
          bin_sr <= bin_sr << 1;
          ovf    <= ovf | carry;
          count  <= count + 1'b1;
          if (count == LAST) begin
            bcd_q <= acc_next;
            ovf_q <= ovf | carry;
            vld_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == SHIFT);
  assign bus.out_valid = vld_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.out_ovf   = ovf_q;

`ifdef BIN2BCD_EXCESS3_EN
  function automatic logic [BCD_W-1:0] to_excess3(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    return r;
  endfunction

  logic [BCD_W-1:0] ex3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex3_q <= '0;
    end else if (state == SHIFT && count == LAST) begin
      ex3_q <= to_excess3(acc_next);
    end
  end

  assign bus.ex3_out = ex3_q;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 3-digit and a 2-digit instance converting the same words.
module tb_bin2bcd_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] bin_in = 8'd0;
  logic       out_ready = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(8), .DIGITS(3)) a_if ();
  bin2bcd_if #(.BIN_W(8), .DIGITS(2)) b_if ();

  assign a_if.in_valid  = in_valid;
  assign a_if.bin_in    = bin_in;
  assign a_if.out_ready = out_ready;
  assign b_if.in_valid  = in_valid;
  assign b_if.bin_in    = bin_in;
  assign b_if.out_ready = out_ready;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept v, check latency, result and hold behaviour, then complete the output handshake.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp3,
                         input logic [7:0] exp2, input logic ovf2,
                         input logic [11:0] ex3, input int hold);
    bin_in   = v;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check("in_ready_before", {15'd0, a_if.in_ready}, 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", {14'd0, b_if.busy, a_if.busy}, 16'd3);
    check("in_ready_shift", {15'd0, a_if.in_ready}, 16'd0);
    repeat (7) @(posedge clk);
    #1;
    check("out_valid_early", {14'd0, b_if.out_valid, a_if.out_valid}, 16'd0);
    @(posedge clk); #1;
    check("out_valid_lat8", {14'd0, b_if.out_valid, a_if.out_valid}, 16'd3);
    check("bcd3", {4'd0, a_if.bcd_out}, {4'd0, exp3});
    check("ovf3", {15'd0, a_if.out_ovf}, 16'd0);
    check("bcd2", {8'd0, b_if.bcd_out}, {8'd0, exp2});
    check("ovf2", {15'd0, b_if.out_ovf}, {15'd0, ovf2});
`ifdef BIN2BCD_EXCESS3_EN
    check("ex3", {4'd0, a_if.ex3_out}, {4'd0, ex3});
`else
    if (ex3 != 12'd0) bin_in = v;
`endif
    for (int i = 0; i < hold; i++) begin
      bin_in   = 8'd7;
      in_valid = (i == 2);
      @(posedge clk); #1;
      check("hold_valid", {15'd0, a_if.out_valid}, 16'd1);
      check("hold_bcd", {4'd0, a_if.bcd_out}, {4'd0, exp3});
      check("hold_in_ready", {15'd0, a_if.in_ready}, 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_after_hs", {14'd0, b_if.out_valid, a_if.out_valid}, 16'd0);
    check("in_ready_after_hs", {15'd0, a_if.in_ready}, 16'd1);
    check("bcd_held_idle", {4'd0, a_if.bcd_out}, {4'd0, exp3});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {15'd0, a_if.out_valid}, 16'd0);
    check("rst_in_ready", {15'd0, a_if.in_ready}, 16'd1);
    check("rst_busy", {15'd0, a_if.busy}, 16'd0);
    check("rst_bcd", {4'd0, a_if.bcd_out}, 16'd0);
    check("rst_ovf", {15'd0, a_if.out_ovf}, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    convert(8'd0,   12'h000, 8'h00, 1'b0, 12'h333, 0);
    convert(8'd255, 12'h255, 8'h55, 1'b1, 12'h588, 0);
    convert(8'd99,  12'h099, 8'h99, 1'b0, 12'h3CC, 5);
    convert(8'd200, 12'h200, 8'h00, 1'b1, 12'h533, 0);
    convert(8'd87,  12'h087, 8'h87, 1'b0, 12'h3BA, 0);

    // Abort a conversion of 123 in its fourth shift cycle with no clock edge involved.
    bin_in   = 8'd123;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {15'd0, a_if.busy}, 16'd0);
    check("async_rst_in_ready", {15'd0, a_if.in_ready}, 16'd1);
    check("async_rst_bcd", {4'd0, a_if.bcd_out}, 16'd0);
    check("async_rst_bcd2", {8'd0, b_if.bcd_out}, 16'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    convert(8'd123, 12'h123, 8'h23, 1'b1, 12'h456, 0);
    convert(8'd209, 12'h209, 8'h09, 1'b1, 12'h53C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
